// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions used by the hold/stall controller and
// its helpers: controller state encoding, the x0 index and default limits.
package riscv_pkg;

    // Controller state: RUN while the pipeline flows, WAIT while a data
    // memory access is outstanding and the pipeline is frozen.
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } ctrl_state_t;

    // x0 is hard-wired to zero, so a load writing it never creates a hazard.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Default watchdog limit in frozen cycles per data memory access.
    localparam int DEF_MAX_WAIT = 8;

    // Width of the watchdog counter; covers the full 1..255 MAX_WAIT range.
    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/pipe_hold_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use hazard term between the D and E
// stages. A load in E whose destination (other than x0) matches either D
// source register must hold D for one cycle.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic       MemRead_E,
    input  logic [4:0] rd_E,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    output logic       lu
);

    assign lu = MemRead_E && (rd_E != REG_X0) &&
                ((rd_E == rs1_D) || (rd_E == rs2_D));

endmodule

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: central stall / flush / freeze controller for the 5-stage
// RV32I pipeline. Merges load-use hazards, E-stage redirects and a multi-cycle
// data memory handshake into one set of write enables and flush controls,
// with a per-access watchdog that abandons accesses that never complete.
//
// Build option: define PIPE_CTRL_PERF_EN to include the performance
// counters; without it the counter ports are tied to zero.
module pipe_hold_ctrl
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_E,
    input  logic [4:0]       rd_E,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             PCSrc_E,
    input  logic             MemRead_M,
    input  logic             MemWrite_M,
    input  logic             dmem_ready,
    input  logic             err_clr,
    output logic             dmem_req,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic             mem_timeout,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    ctrl_state_t             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    mem_err_q, mem_err_d;

    logic acc;
    logic lu;
    logic abort;
    logic freeze;

    load_use_detect u_load_use_detect (
        .MemRead_E (MemRead_E),
        .rd_E      (rd_E),
        .rs1_D     (rs1_D),
        .rs2_D     (rs2_D),
        .lu        (lu)
    );

    assign acc    = MemRead_M | MemWrite_M;
    // The watchdog fires once the access has sat in WAIT for MAX_WAIT cycles,
    // i.e. after MAX_WAIT + 1 frozen cycles counting the entry cycle in RUN.
    assign abort  = (state_q == WAIT) && (wait_cnt_q == MAX_WAIT_C);
    assign freeze = acc && !dmem_ready && !abort;

    // Next-state logic for the wait FSM, watchdog counter and sticky error.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (freeze) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ready || abort) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != MAX_WAIT_C) begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        // Set beats clear so an abort is never lost to a concurrent err_clr.
        if (abort) begin
            mem_err_d = 1'b1;
        end else if (err_clr) begin
            mem_err_d = 1'b0;
        end else begin
            mem_err_d = mem_err_q;
        end
    end

    // FSM state, watchdog and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    // Priority mux: reset, then freeze, then abort, then redirect, then load-use.
    always_comb begin
        dmem_req     = acc && !abort;
        mem_timeout  = abort;
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Write  = 1'b1;
        EX_MEM_Write = 1'b1;
        MEM_WB_Write = 1'b1;
        Flush_D      = 1'b0;
        Flush_E      = 1'b0;
        Flush_W      = 1'b0;
        if (!rst_n) begin
            // Held quiet during reset; this also withdraws an in-flight request.
            dmem_req     = 1'b0;
            mem_timeout  = 1'b0;
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end else if (freeze) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end else if (abort) begin
            // The abandoned access retires as a bubble into WB.
            Flush_W = 1'b1;
        end else if (PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (lu) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            Flush_E     = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic             redirect;
    logic             lu_bubble;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign redirect  = !freeze && !abort && PCSrc_E;
    assign lu_bubble = !freeze && !abort && !PCSrc_E && lu;

    // Event counters; they wrap naturally at 2^CNT_W.
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(freeze);
        lu_cnt_d    = lu_cnt_q    + CNT_W'(lu_bubble);
        flush_cnt_d = flush_cnt_q + CNT_W'(redirect);
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            lu_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign lu_cnt    = lu_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign lu_cnt    = '0;
    assign flush_cnt = '0;
`endif

endmodule
